// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the multi-port register file.
//   - rf_state_e : clear-sequencer state encoding
//   - default width constants used by reg_file_mp parameters
package rf_pkg;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

    typedef enum logic {
        RF_ST_IDLE  = 1'b0,
        RF_ST_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of reg_file_mp.
// Ports:
//   raddr_i             read address
//   arr_data_i          array contents at raddr_i (pre-edge state)
//   we0_i/waddr0_i/wdata0_i, we1_i/waddr1_i/wdata1_i  write-port snoop
//   busy_i              clear sequence running: forces 0, disables bypass
//   rdata_o             read data
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] arr_data_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              busy_i,
    output logic [DATA_W-1:0] rdata_o
);

    always_comb begin
        rdata_o = arr_data_i;
        // Port 1 is checked first so forwarding matches what the array stores.
        if (BYPASS != 0) begin
            if (we1_i && (waddr1_i == raddr_i))
                rdata_o = wdata1_i;
            else if (we0_i && (waddr0_i == raddr_i))
                rdata_o = wdata0_i;
        end
        // Zero overrides win over bypass so a dropped r0 write never leaks out.
        if (busy_i || ((ZERO_REG != 0) && (raddr_i == '0)))
            rdata_o = '0;
    end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-read / 2-write register file with a clear sequencer.
// Ports:
//   RF_clk, RF_rst (sync, active-high)
//   RF_clear_req        start a full-array clear (IDLE only)
//   RF_busy             clear sequence running
//   RF_raddr_a/b, RF_rdata_a/b   combinational read ports
//   RF_we0/waddr0/wdata0         write port 0
//   RF_we1/waddr1/wdata1         write port 1 (wins on address collision)
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              RF_clk,
    input  logic              RF_rst,
    input  logic              RF_clear_req,
    output logic              RF_busy,
    input  logic [ADDR_W-1:0] RF_raddr_a,
    input  logic [ADDR_W-1:0] RF_raddr_b,
    output logic [DATA_W-1:0] RF_rdata_a,
    output logic [DATA_W-1:0] RF_rdata_b,
    input  logic              RF_we0,
    input  logic [ADDR_W-1:0] RF_waddr0,
    input  logic [DATA_W-1:0] RF_wdata0,
    input  logic              RF_we1,
    input  logic [ADDR_W-1:0] RF_waddr1,
    input  logic [DATA_W-1:0] RF_wdata1
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    logic busy;
    logic wen0, wen1;

    assign busy    = (state_q == RF_ST_CLEAR);
    assign RF_busy = busy;

    // Writes to r0 are dropped at the array so a later ZERO_REG=0 build
    // would need no other change here.
    assign wen0 = RF_we0 && !((ZERO_REG != 0) && (RF_waddr0 == '0));
    assign wen1 = RF_we1 && !((ZERO_REG != 0) && (RF_waddr1 == '0));

    // ---------------- clear sequencer ----------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_ST_CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LAST_IDX)
                    state_d = RF_ST_IDLE;
            end
            RF_ST_IDLE: begin
                if (RF_clear_req) begin
                    state_d   = RF_ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = RF_ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge RF_clk) begin
        if (RF_rst) begin
            state_q   <= RF_ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // ---------------- array ----------------
    // No reset on the array itself: the post-reset clear defines contents.
    always_ff @(posedge RF_clk) begin
        if (!RF_rst) begin
            if (busy) begin
                mem_q[clr_idx_q] <= '0;
            end else begin
                if (wen0) mem_q[RF_waddr0] <= RF_wdata0;
                // Later assignment wins: port 1 has priority on collision.
                if (wen1) mem_q[RF_waddr1] <= RF_wdata1;
            end
        end
    end

    // ---------------- read ports ----------------
    rf_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd_a (
        .raddr_i   (RF_raddr_a),
        .arr_data_i(mem_q[RF_raddr_a]),
        .we0_i     (RF_we0),
        .waddr0_i  (RF_waddr0),
        .wdata0_i  (RF_wdata0),
        .we1_i     (RF_we1),
        .waddr1_i  (RF_waddr1),
        .wdata1_i  (RF_wdata1),
        .busy_i    (busy),
        .rdata_o   (RF_rdata_a)
    );

    rf_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd_b (
        .raddr_i   (RF_raddr_b),
        .arr_data_i(mem_q[RF_raddr_b]),
        .we0_i     (RF_we0),
        .waddr0_i  (RF_waddr0),
        .wdata0_i  (RF_wdata0),
        .we1_i     (RF_we1),
        .waddr1_i  (RF_waddr1),
        .wdata1_i  (RF_wdata1),
        .busy_i    (busy),
        .rdata_o   (RF_rdata_b)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        busy;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;

    int checks   = 0;
    int failures = 0;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .RF_clk      (clk),
        .RF_rst      (rst),
        .RF_clear_req(clear_req),
        .RF_busy     (busy),
        .RF_raddr_a  (raddr_a),
        .RF_raddr_b  (raddr_b),
        .RF_rdata_a  (rdata_a),
        .RF_rdata_b  (rdata_b),
        .RF_we0      (we0),
        .RF_waddr0   (waddr0),
        .RF_wdata0   (wdata0),
        .RF_we1      (we1),
        .RF_waddr1   (waddr1),
        .RF_wdata1   (wdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; samples are taken after a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until busy drops (bounded), returns number of ticks taken.
    task automatic busy_ticks(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 100);
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    // OR of every register seen through both ports.
    task automatic or_all(output logic [31:0] acc);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #0.1;
            acc = acc | rdata_a | rdata_b;
        end
    endtask

    initial begin
        int n;
        logic [31:0] acc;
        rst = 1'b1; clear_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr_a = 5'd3; raddr_b = 5'd17;

        // Reset and the mandatory clear
        tick();
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_rdata_b", rdata_b, 32'd0);
        rst = 1'b0;
        busy_ticks(n);
        chk("init_clear_cycles", n, 32);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        or_all(acc);
        chk("init_all_zero", acc, 32'd0);

        // Single write on port 0, bypass then array read
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        raddr_a = 5'd5; raddr_b = 5'd6;
        #1;
        chk("wr5_bypass", rdata_a, 32'hDEADBEEF);
        chk("wr5_other_port", rdata_b, 32'd0);
        tick();
        we0 = 1'b0;
        #1;
        chk("wr5_array", rdata_a, 32'hDEADBEEF);

        // Collision on address 7: port 1 wins
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr_b = 5'd7;
        #1;
        chk("coll_bypass", rdata_b, 32'h22);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("coll_array", rdata_b, 32'h22);

        // Distinct addresses on both ports
        we0 = 1'b1; waddr0 = 5'd9;  wdata0 = 32'h000000A5;
        we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h0000005A;
        raddr_a = 5'd9; raddr_b = 5'd10;
        #1;
        chk("dual_byp_a", rdata_a, 32'h000000A5);
        chk("dual_byp_b", rdata_b, 32'h0000005A);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("dual_arr_a", rdata_a, 32'h000000A5);
        chk("dual_arr_b", rdata_b, 32'h0000005A);

        // Hardwired zero register
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        raddr_a = 5'd0;
        #1;
        chk("r0_same_cycle", rdata_a, 32'd0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("r0_next_cycle", rdata_a, 32'd0);

        // Fill 1..31 with nonzero values
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'h01010100 | 32'(i);
            tick();
        end
        we0 = 1'b0;
        raddr_a = 5'd31; raddr_b = 5'd1;
        #1;
        chk("fill_r31", rdata_a, 32'h0101011F);
        chk("fill_r1", rdata_b, 32'h01010101);

        // Clear request with a concurrent write, writes held during clear
        clear_req = 1'b1;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h77;
        tick();
        clear_req = 1'b0;
        we0 = 1'b1; waddr0 = 5'd4;  wdata0 = 32'h1234;
        we1 = 1'b1; waddr1 = 5'd30; wdata1 = 32'h5678;
        raddr_a = 5'd31;
        #1;
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("clr_read_zero", rdata_a, 32'd0);
        busy_ticks(n);
        chk("clr_cycles", n, 32);
        or_all(acc);
        chk("clr_all_zero", acc, 32'd0);

        // Reset in the middle of a clear restarts the count
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hCAFE;
        tick();
        we0 = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        busy_ticks(n);
        chk("midrst_cycles", n, 32);
        or_all(acc);
        chk("midrst_all_zero", acc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the MIPS datapath, successor to the single-write-port register bank. Provides two combinational read ports and two clocked write ports with a fixed priority, write-to-read bypass and optional hardwired-zero register 0. A clear sequencer zeroes the whole array after reset or on request, one entry per cycle, and reports busy meanwhile. Sits between decode (read addresses) and writeback (write ports) in the pipelined core.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port
- RF_clk  in  1  single clock, all state updates on rising edge
- RF_rst  in  1  synchronous, active-high reset
- RF_clear_req  in  1  pulse: start a full-array clear
- RF_busy  out  1  high while clear sequence runs
- RF_raddr_a  in  ADDR_W  read port A address
- RF_raddr_b  in  ADDR_W  read port B address
- RF_rdata_a  out  DATA_W  read port A data
- RF_rdata_b  out  DATA_W  read port B data
- RF_we0  in  1  write port 0 enable
- RF_waddr0  in  ADDR_W  write port 0 address
- RF_wdata0  in  DATA_W  write port 0 data
- RF_we1  in  1  write port 1 enable (priority port)
- RF_waddr1  in  ADDR_W  write port 1 address
- RF_wdata1  in  DATA_W  write port 1 data

## Operation
- FSM states: CLEAR, IDLE. Clear counter clr_idx, ADDR_W bits.
- RF_rst=1 at an edge: state <= CLEAR, clr_idx <= 0. Reset asserted mid-clear restarts from 0.
- CLEAR: each cycle mem[clr_idx] <= 0, clr_idx increments; at clr_idx = DEPTH-1 the entry is cleared and state <= IDLE. All writes ignored. RF_clear_req ignored. Both read ports return 0 (bypass disabled).
- IDLE: RF_clear_req=1 -> state <= CLEAR, clr_idx <= 0; writes presented in that same cycle are still performed (clear overwrites them later).
- Write: on edge in IDLE, port 0 then port 1 applied; same address on both ports -> port 1 data stored. Address 0 writes dropped when ZERO_REG=1.
- Read: combinational from array. ZERO_REG=1 and address 0 -> 0 regardless of bypass.
- Bypass (BYPASS=1, IDLE only): if RF_we1 and RF_waddr1 matches read address -> RF_wdata1; else if RF_we0 and RF_waddr0 matches -> RF_wdata0; else array. BYPASS=0: read returns pre-edge array contents.
- RF_busy = (state == CLEAR), registered state, no combinational path from inputs.

## Timing
- During reset and the cycle after: RF_busy=1, RF_rdata_a/b = 0.
- Clear takes exactly DEPTH cycles: RF_busy rises the edge after reset/request and falls after DEPTH edges in CLEAR (32 cycles at defaults).
- Write latency: data visible on array read path the cycle after the write edge; with BYPASS=1 visible combinationally in the write cycle.
- Read latency: zero cycles (combinational address->data).
- Initial array contents before first reset undefined; the mandatory post-reset clear defines them.

## Structure
- Shared package rf_pkg: FSM state encoding (RF_ST_IDLE, RF_ST_CLEAR) and default width constants.
- One natural sub-module: rf_read_port (address, array data, two write-port snoop inputs, busy, ZERO_REG/BYPASS params -> read data), instantiated twice.
- Clear FSM, counter and array in the top module.

## Test plan
- Reset 1 cycle, release -> RF_busy=1 for 32 cycles, then 0; every address reads 0.
- IDLE, we0 addr 5 data 0xDEADBEEF -> next cycle raddr_a=5 reads 0xDEADBEEF; with BYPASS=1 read in write cycle also returns 0xDEADBEEF.
- we0 and we1 both addr 7, data 0x11 and 0x22 -> addr 7 reads 0x22 afterwards and 0x22 via bypass.
- Write 0xFFFFFFFF to addr 0 with ZERO_REG=1 -> addr 0 reads 0 in same and next cycle.
- Fill regs 1..31 with nonzero, pulse RF_clear_req -> busy 32 cycles, writes during clear dropped, all regs 0 after.
- Assert RF_rst at clear cycle 10 -> clr_idx restarts, RF_busy stays high for a full 32 cycles after release.
